// File: rtl/pong_score_pkg.sv
// Shared types and constants for the pong score keeper.
// Scores are single display digits, so they saturate at MAX_DIGIT.
package pong_score_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        POINT_WAIT,
        SERVE_WAIT,
        GAME_OVER
    } state_t;

    localparam int POINTS_W = 4;
    localparam int MAX_DIGIT = 9;

    localparam logic PLAYER_FIRST  = 1'b0;
    localparam logic PLAYER_SECOND = 1'b1;

    function automatic logic [POINTS_W-1:0] sat_inc(input logic [POINTS_W-1:0] value);
        return (value >= POINTS_W'(MAX_DIGIT)) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector: pulses in the first high cycle of level (combinational from level, 0-cycle).
// A level already high when reset releases must drop low once before it can count.
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;
    logic armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev <= level;
            if (!level) begin
                armed <= 1'b1;
            end
        end
    end

    assign rise = level & ~prev & armed;

endmodule

// File: rtl/score_keeper.sv
// Pong match controller: goal edges -> registered scores, rally FSM, ball enable; 1-cycle latency, no backpressure.
// Build option AUTO_SERVE_EN: the post-point pause relaunches the ball without waiting for serve_btn.
module score_keeper
    import pong_score_pkg::*;
#(
    parameter int WIN_SCORE   = 5,
    parameter int POINT_DELAY = 65_000_000,
    parameter int DLY_W       = $clog2(POINT_DELAY + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                goal_left,
    input  logic                goal_right,
    input  logic                serve_btn,
    input  logic                new_game,
    output logic [POINTS_W-1:0] points_first_player,
    output logic [POINTS_W-1:0] points_second_player,
    output logic                ball_run,
    output logic                serve_dir,
    output logic                game_over,
    output logic                winner
);

    localparam logic [POINTS_W-1:0] WIN_PTS  = POINTS_W'(WIN_SCORE);
    localparam logic [DLY_W-1:0]    DLY_LOAD = DLY_W'(POINT_DELAY);
    localparam logic [DLY_W-1:0]    DLY_LAST = DLY_W'(1);

    logic left_rise;
    logic right_rise;
    logic serve_rise;
    logic new_rise;

    rise_edge u_left  (.clk(clk), .rst(rst), .level(goal_left),  .rise(left_rise));
    rise_edge u_right (.clk(clk), .rst(rst), .level(goal_right), .rise(right_rise));
    rise_edge u_serve (.clk(clk), .rst(rst), .level(serve_btn),  .rise(serve_rise));
    rise_edge u_new   (.clk(clk), .rst(rst), .level(new_game),   .rise(new_rise));

    state_t              state;
    logic [DLY_W-1:0]    dly_cnt;
    logic [POINTS_W-1:0] first_next;
    logic [POINTS_W-1:0] second_next;

    assign first_next  = sat_inc(points_first_player);
    assign second_next = sat_inc(points_second_player);

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            dly_cnt              <= '0;
            points_first_player  <= '0;
            points_second_player <= '0;
            ball_run             <= 1'b0;
            serve_dir            <= PLAYER_FIRST;
            game_over            <= 1'b0;
            winner               <= PLAYER_FIRST;
        end else if (new_rise) begin
            state                <= IDLE;
            dly_cnt              <= '0;
            points_first_player  <= '0;
            points_second_player <= '0;
            ball_run             <= 1'b0;
            serve_dir            <= PLAYER_FIRST;
            game_over            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (serve_rise) begin
                        state    <= PLAY;
                        ball_run <= 1'b1;
                    end
                end
                PLAY: begin
                    // A simultaneous double goal is a dead ball: replay after the pause.
                    if (left_rise && right_rise) begin
                        state    <= POINT_WAIT;
                        dly_cnt  <= DLY_LOAD;
                        ball_run <= 1'b0;
                    end else if (right_rise) begin
                        points_first_player <= first_next;
                        serve_dir           <= PLAYER_SECOND;
                        ball_run            <= 1'b0;
                        if (first_next == WIN_PTS) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                            winner    <= PLAYER_FIRST;
                        end else begin
                            state   <= POINT_WAIT;
                            dly_cnt <= DLY_LOAD;
                        end
                    end else if (left_rise) begin
                        points_second_player <= second_next;
                        serve_dir            <= PLAYER_FIRST;
                        ball_run             <= 1'b0;
                        if (second_next == WIN_PTS) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                            winner    <= PLAYER_SECOND;
                        end else begin
                            state   <= POINT_WAIT;
                            dly_cnt <= DLY_LOAD;
                        end
                    end
                end
                POINT_WAIT: begin
                    if (dly_cnt <= DLY_LAST) begin
                        dly_cnt <= '0;
`ifdef AUTO_SERVE_EN
                        state    <= PLAY;
                        ball_run <= 1'b1;
`else
                        state <= SERVE_WAIT;
`endif
                    end else begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end
                end
`ifndef AUTO_SERVE_EN
                SERVE_WAIT: begin
                    if (serve_rise) begin
                        state    <= PLAY;
                        ball_run <= 1'b1;
                    end
                end
`endif
                GAME_OVER: begin
                    ball_run <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    ball_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper with WIN_SCORE=3, POINT_DELAY=4; expectations are queued per cycle
// by the driver and checked by an independent monitor on the falling edge.
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       goal_left;
    logic       goal_right;
    logic       serve_btn;
    logic       new_game;
    logic [3:0] points_first_player;
    logic [3:0] points_second_player;
    logic       ball_run;
    logic       serve_dir;
    logic       game_over;
    logic       winner;

`ifdef AUTO_SERVE_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif

    score_keeper #(.WIN_SCORE(3), .POINT_DELAY(4)) dut (
        .clk(clk),
        .rst(rst),
        .goal_left(goal_left),
        .goal_right(goal_right),
        .serve_btn(serve_btn),
        .new_game(new_game),
        .points_first_player(points_first_player),
        .points_second_player(points_second_player),
        .ball_run(ball_run),
        .serve_dir(serve_dir),
        .game_over(game_over),
        .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        string      tag;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       br;
        logic       sd;
        logic       go;
        logic       win;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         vectors = 0;
    int         errors = 0;
    string      tag = "reset";
    logic [3:0] ep1 = 4'd0;
    logic [3:0] ep2 = 4'd0;
    logic       ebr = 1'b0;
    logic       esd = 1'b0;
    logic       ego = 1'b0;
    logic       ewin = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every expectation that has come due and compares all outputs.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            mon_e = q.pop_front();
            vectors++;
            if (mon_e.due != cyc ||
                {points_first_player, points_second_player, ball_run, serve_dir, game_over, winner} !==
                {mon_e.p1, mon_e.p2, mon_e.br, mon_e.sd, mon_e.go, mon_e.win}) begin
                errors++;
                $display("FAIL %s cyc=%0d: got p1=%0d p2=%0d run=%b dir=%b over=%b win=%b, want p1=%0d p2=%0d run=%b dir=%b over=%b win=%b",
                         mon_e.tag, cyc, points_first_player, points_second_player, ball_run, serve_dir,
                         game_over, winner, mon_e.p1, mon_e.p2, mon_e.br, mon_e.sd, mon_e.go, mon_e.win);
            end
        end
    end

    // One clock of stimulus; the current e* values are the outputs expected after this edge.
    task automatic tick(input logic r, input logic gl, input logic gr, input logic sb, input logic ng);
        rst        = r;
        goal_left  = gl;
        goal_right = gr;
        serve_btn  = sb;
        new_game   = ng;
        q.push_back('{due: cyc + 1, tag: tag, p1: ep1, p2: ep2, br: ebr, sd: esd, go: ego, win: ewin});
        @(posedge clk);
        #1;
    endtask

    task automatic goal(input logic left, input logic [3:0] score, input logic over);
        if (left) begin
            ep2 = score;
            esd = 1'b0;
        end else begin
            ep1 = score;
            esd = 1'b1;
        end
        ebr = 1'b0;
        if (over) begin
            ego  = 1'b1;
            ewin = left;
        end
        tick(0, left, !left, 0, 0);
    endtask

    task automatic pause();
        ebr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) ebr = AUTO;
            tick(0, 0, 0, 0, 0);
        end
    endtask

    task automatic serve();
        ebr = 1'b1;
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; goal_left = 1'b0; goal_right = 1'b0; serve_btn = 1'b0; new_game = 1'b0;
        @(posedge clk);
        #1;
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tag = "idle";
        tick(0, 0, 0, 0, 0);

        tag = "t1_serve";
        serve();
        tag = "t1_goal_held";
        goal(0, 4'd1, 0);
        for (int i = 1; i <= 9; i++) begin
            if (i == 4) ebr = AUTO;
            tick(0, 0, 1, 0, 0);
        end
        tick(0, 0, 0, 0, 0);
        tag = "t1_serve2";
        serve();

        tag = "t2_double_goal";
        ebr = 1'b0;
        tick(0, 1, 1, 0, 0);
        pause();
        tag = "t2_first_serve_cycle";
        serve();

        tag = "t5_serve_in_pause";
        goal(1, 4'd1, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0);
        ebr = AUTO;
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0);
        tag = "t5_serve_in_wait";
        ebr = 1'b1;
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0);

        tag = "t6_rst_in_pause";
        goal(0, 4'd2, 0);
        tick(0, 0, 0, 0, 0);
        ep1 = 4'd0; ep2 = 4'd0; ebr = 1'b0; esd = 1'b0; ego = 1'b0; ewin = 1'b0;
        tick(1, 0, 1, 0, 0);
        tick(1, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0);
        tag = "t6_goal_held_thru_rst";
        ebr = 1'b1;
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0);

        tag = "t3_first_wins";
        goal(0, 4'd1, 0);
        pause();
        serve();
        goal(0, 4'd2, 0);
        pause();
        serve();
        goal(0, 4'd3, 1);
        tag = "t3_frozen";
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0);

        tag = "t4_new_game";
        ep1 = 4'd0; ep2 = 4'd0; esd = 1'b0; ego = 1'b0; ebr = 1'b0;
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        tag = "t4_idle_ignores_goal";
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        serve();
        tag = "t4_new_game_over_goal";
        ebr = 1'b0;
        tick(0, 1, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        serve();

        tag = "second_wins";
        goal(1, 4'd1, 0);
        pause();
        serve();
        goal(1, 4'd2, 0);
        pause();
        serve();
        goal(1, 4'd3, 1);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
